// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - shared constants and helpers for the tick generator
package tick_gen_pkg;

    localparam int DEFAULT_CNT_W = 24;
    localparam int unsigned DIV_10MS_100M = 1000000;
    // sq runs at mclk/(2*div), so a divisor of 2 yields 25 MHz from 100 MHz
    localparam int unsigned DIV_VGA25 = 2;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_gen_multi_if.sv
// rtl/tick_gen_multi_if.sv - divisor configuration port of the tick generator
interface tick_gen_multi_if
    import tick_gen_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = DEFAULT_CNT_W,
    parameter int CH_W  = clog2_min1(NCH)
);
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ack;
    logic             cfg_err;

    modport master (
        output cfg_we, cfg_ch, cfg_div,
        input  cfg_ack, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_div,
        output cfg_ack, cfg_err
    );

endinterface

// File: rtl/tick_chan.sv
// rtl/tick_chan.sv - one tick/square-wave channel with shadowed divisor
module tick_chan
    import tick_gen_pkg::*;
#(
    parameter int          CNT_W    = DEFAULT_CNT_W,
    parameter int unsigned DIV_INIT = DIV_10MS_100M
) (
    input  logic             mclk,
    input  logic             clr,
    input  logic             en_i,
    input  logic             restart_i,
    input  logic             apply_i,
    input  logic [CNT_W-1:0] apply_div_i,
    output logic             tick_o,
    output logic             sq_o
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_INIT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic [CNT_W-1:0] last_cnt;
    logic             running;
    logic             wrap;

    always_comb begin
        last_cnt = (div_q == '0) ? '0 : div_q - ONE;
        running  = en_i && (div_q != '0);
        wrap     = running && (cnt_q == last_cnt);
        cnt_d    = cnt_q;
        div_d    = div_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        tick_d   = 1'b0;
        sq_d     = sq_q;
        if (restart_i) begin
            cnt_d    = '0;
            sq_d     = 1'b0;
            pend_v_d = 1'b0;
            if (apply_i) begin
                div_d  = apply_div_i;
                pend_d = apply_div_i;
            end else if (pend_v_q) begin
                div_d = pend_q;
            end
        end else begin
            if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
                if (pend_v_q) begin
                    div_d    = pend_q;
                    pend_v_d = 1'b0;
                end
            end else if (running) begin
                cnt_d = cnt_q + ONE;
            end else if (pend_v_q) begin
                // a stopped channel has no wrap to wait for, so take the new divisor now
                div_d    = pend_q;
                pend_v_d = 1'b0;
                cnt_d    = '0;
            end
            // a write landing on a wrap edge stays pending for the following wrap
            if (apply_i) begin
                pend_d   = apply_div_i;
                pend_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge mclk or posedge clr) begin
        if (clr) begin
            cnt_q    <= '0;
            div_q    <= DIV_RST;
            pend_q   <= DIV_RST;
            pend_v_q <= 1'b0;
            tick_q   <= 1'b0;
            sq_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            tick_q   <= tick_d;
            sq_q     <= sq_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;

endmodule

// File: rtl/tick_gen_multi.sv
// rtl/tick_gen_multi.sv - N-channel programmable tick and square-wave generator
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int          NCH      = 4,
    parameter int          CNT_W    = DEFAULT_CNT_W,
    parameter int unsigned DIV_INIT = DIV_10MS_100M
) (
    input  logic                   mclk,
    input  logic                   clr,
    input  logic                   sync_rst,
    input  logic [NCH-1:0]         en,
    tick_gen_multi_if.slave        cfg,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         sq
);

    localparam int CH_W = clog2_min1(NCH);
    localparam logic [CH_W:0] NCH_L = (CH_W + 1)'(NCH);

    logic cfg_valid;
    logic cfg_ack_q;
    logic cfg_err_q;

    // extra bit so an index equal to NCH is representable when NCH is a power of two
    assign cfg_valid = cfg.cfg_we && ({1'b0, cfg.cfg_ch} < NCH_L);

    always_ff @(posedge mclk or posedge clr) begin
        if (clr) begin
            cfg_ack_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_ack_q <= cfg_valid;
            cfg_err_q <= cfg.cfg_we && !cfg_valid;
        end
    end

    assign cfg.cfg_ack = cfg_ack_q;
    assign cfg.cfg_err = cfg_err_q;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic sel;
        assign sel = cfg_valid && (cfg.cfg_ch == CH_W'(i));

        tick_chan #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT)
        ) u_chan (
            .mclk        (mclk),
            .clr         (clr),
            .en_i        (en[i]),
            .restart_i   (sync_rst),
            .apply_i     (sel),
            .apply_div_i (cfg.cfg_div),
            .tick_o      (tick[i]),
            .sq_o        (sq[i])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb/tb_tick_gen_multi.sv - randomized and directed bench for tick_gen_multi
module tb_tick_gen_multi;

    localparam int NCH   = 5;
    localparam int CNT_W = 24;
    localparam int DINIT = 10;
    localparam int CH_W  = 3;

    logic           mclk;
    logic           clr;
    logic           sync_rst;
    logic [NCH-1:0] en;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;

    int checks   = 0;
    int failures = 0;

    tick_gen_multi_if #(.NCH(NCH), .CNT_W(CNT_W)) cfg_if ();

    tick_gen_multi #(.NCH(NCH), .CNT_W(CNT_W), .DIV_INIT(DINIT)) dut (
        .mclk     (mclk),
        .clr      (clr),
        .sync_rst (sync_rst),
        .en       (en),
        .cfg      (cfg_if),
        .tick     (tick),
        .sq       (sq)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    // reference: rem[i] = edges left until channel i completes its period
    int m_div [NCH];
    int m_pend[NCH];
    bit m_pv  [NCH];
    int m_rem [NCH];
    bit m_tick[NCH];
    bit m_sq  [NCH];
    bit m_ack, m_err;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge mclk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NCH; i++) begin
                m_div[i] = DINIT; m_pend[i] = DINIT; m_pv[i] = 0;
                m_rem[i] = DINIT; m_tick[i] = 0; m_sq[i] = 0;
            end
            m_ack = 0; m_err = 0;
        end else begin
            bit valid;
            int ch, nd;
            ch    = int'(cfg_if.cfg_ch);
            nd    = int'(cfg_if.cfg_div);
            valid = cfg_if.cfg_we && (ch < NCH);
            m_ack = valid;
            m_err = cfg_if.cfg_we && !valid;
            for (int i = 0; i < NCH; i++) begin
                bit w;
                w = valid && (ch == i);
                m_tick[i] = 0;
                if (sync_rst) begin
                    m_sq[i] = 0;
                    if (w) begin m_div[i] = nd; m_pend[i] = nd; end
                    else if (m_pv[i]) m_div[i] = m_pend[i];
                    m_pv[i]  = 0;
                    m_rem[i] = m_div[i];
                end else begin
                    if (en[i] && m_div[i] > 0) begin
                        if (m_rem[i] == 1) begin
                            m_tick[i] = 1;
                            m_sq[i]   = !m_sq[i];
                            if (m_pv[i]) begin m_div[i] = m_pend[i]; m_pv[i] = 0; end
                            m_rem[i] = m_div[i];
                        end else begin
                            m_rem[i] = m_rem[i] - 1;
                        end
                    end else if (m_pv[i]) begin
                        m_div[i] = m_pend[i]; m_pv[i] = 0; m_rem[i] = m_div[i];
                    end
                    if (w) begin m_pend[i] = nd; m_pv[i] = 1; end
                end
            end
        end
    end

    always @(negedge mclk) begin
        logic [NCH-1:0] et, es;
        for (int i = 0; i < NCH; i++) begin et[i] = m_tick[i]; es[i] = m_sq[i]; end
        check("model_tick", tick, et);
        check("model_sq", sq, es);
        check("model_ack_err", {cfg_if.cfg_ack, cfg_if.cfg_err}, {m_ack, m_err});
    end

    task automatic step(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic write(input int ch, input int dv);
        cfg_if.cfg_we  = 1'b1;
        cfg_if.cfg_ch  = CH_W'(ch);
        cfg_if.cfg_div = CNT_W'(dv);
        @(negedge mclk);
        cfg_if.cfg_we  = 1'b0;
    endtask

    task automatic wait_tick(input int ch, input int maxc, output int n);
        n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (!tick[ch] && n < maxc);
    endtask

    int n;
    int first[4];
    logic s_hold;
    logic prev_sq;

    initial begin
        clr = 1'b1; sync_rst = 1'b0; en = '0;
        cfg_if.cfg_we = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0;
        #1;
        check("reset_tick", tick, 0);
        check("reset_sq", sq, 0);
        check("reset_ack", cfg_if.cfg_ack, 0);
        en = 5'b00001;
        step(3);
        clr = 1'b0;

        wait_tick(0, 30, n); check("t1_first_tick", n, 10); check("t1_sq_a", sq[0], 1);
        wait_tick(0, 30, n); check("t1_second_tick", n, 10); check("t1_sq_b", sq[0], 0);
        wait_tick(0, 30, n); check("t1_third_tick", n, 10); check("t1_sq_c", sq[0], 1);
        check("t1_other_ticks", tick[4:1], 0);

        write(1, 5);
        check("t2_ack", cfg_if.cfg_ack, 1);
        step(1);
        en[1] = 1'b1;
        wait_tick(1, 30, n); check("t2_div5_tick", n, 5);
        step(2);
        write(1, 3);
        check("t2_ack_b", cfg_if.cfg_ack, 1);
        wait_tick(1, 30, n); check("t2_old_period_rest", n, 2);
        wait_tick(1, 30, n); check("t2_new_period_a", n, 3);
        wait_tick(1, 30, n); check("t2_new_period_b", n, 3);

        write(1, 6);
        wait_tick(1, 30, n); check("t3_apply6", n, 2);
        step(5);
        write(1, 4);
        check("t3_wrap_tick", tick[1], 1);
        wait_tick(1, 30, n); check("t3_old_period", n, 6);
        wait_tick(1, 30, n); check("t3_new_period", n, 4);
        en[1] = 1'b0;
        write(1, 7);
        step(1);
        en[1] = 1'b1;
        wait_tick(1, 30, n); check("t3_disabled_write", n, 7);

        write(2, 1);
        step(1);
        en[2] = 1'b1;
        step(1);
        prev_sq = sq[2];
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("t4_div1_tick", tick[2], 1);
            check("t4_div1_sq_toggle", sq[2], !prev_sq);
            prev_sq = sq[2];
        end
        write(2, 0);
        step(2);
        s_hold = sq[2];
        step(4);
        check("t4_div0_tick", tick[2], 0);
        check("t4_div0_sq_hold", sq[2], s_hold);
        write(5, 9);
        check("t4_err", cfg_if.cfg_err, 1);
        check("t4_err_noack", cfg_if.cfg_ack, 0);

        en = '0;
        write(0, 3); write(1, 4); write(2, 5); write(3, 6);
        step(1);
        en = 5'b01111;
        step(7 + int'($urandom_range(0, 13)));
        sync_rst = 1'b1;
        step(1);
        sync_rst = 1'b0;
        check("t5_sq_cleared", sq[3:0], 0);
        check("t5_tick_cleared", tick[3:0], 0);
        for (int i = 0; i < 4; i++) first[i] = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            for (int i = 0; i < 4; i++) if (tick[i] && first[i] == 0) first[i] = k;
        end
        for (int i = 0; i < 4; i++) check("t5_first_tick", first[i], 3 + i);

        step(int'($urandom_range(1, 4)));
        cfg_if.cfg_we = 1'b1; cfg_if.cfg_ch = 3'd4; cfg_if.cfg_div = 24'd2;
        @(posedge mclk);
        #1;
        check("t6_ack_before_clr", cfg_if.cfg_ack, 1);
        #2 clr = 1'b1;
        #1;
        check("t6_async_tick", tick, 0);
        check("t6_async_sq", sq, 0);
        check("t6_async_ack", cfg_if.cfg_ack, 0);
        cfg_if.cfg_we = 1'b0;
        @(negedge mclk);
        en = 5'b00001;
        clr = 1'b0;
        wait_tick(0, 30, n); check("t6_first_after_clr", n, DINIT);

        for (int k = 0; k < 3000; k++) begin
            @(negedge mclk);
            if ($urandom_range(0, 7) == 0) en = NCH'($urandom);
            sync_rst       = ($urandom_range(0, 59) == 0);
            cfg_if.cfg_we  = ($urandom_range(0, 3) == 0);
            cfg_if.cfg_ch  = CH_W'($urandom_range(0, 7));
            cfg_if.cfg_div = CNT_W'($urandom_range(0, 9));
        end
        @(negedge mclk);
        cfg_if.cfg_we = 1'b0;
        sync_rst = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
